// File: rtl/fifo_uart_pkg.sv
// Shared types and constants for the FIFO-drain UART transmitter.
package fifo_uart_pkg;

  localparam int unsigned DEFAULT_CLKS_PER_BIT = 139;
  localparam int unsigned IDLE_GAP_CYCLES      = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_tx_state_t;

endpackage

// File: rtl/fifo_uart_tx_if.sv
// FIFO read-side and UART line signals of fifo_uart_tx.
// master: the transmitter; slave: FIFO / line environment.
interface fifo_uart_tx_if #(
  parameter int unsigned DATA_W = 8
);
  logic              enable;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_rd_en;
  logic              tx;
  logic              busy;
  logic              frame_done;
  logic [15:0]       bytes_sent;

  modport master (
    input  enable, fifo_empty, fifo_data,
    output fifo_rd_en, tx, busy, frame_done, bytes_sent
  );

  modport slave (
    output enable, fifo_empty, fifo_data,
    input  fifo_rd_en, tx, busy, frame_done, bytes_sent
  );
endinterface

// File: rtl/fifo_uart_tx_baud.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1, bit_end_o on the last count,
// synchronous reload to 0 whenever the transmitter changes state.
module uart_baud_gen
  import fifo_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic reload_i,
  output logic bit_end_o
);
  localparam int unsigned     CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // next count: wrap at the end of a bit period or on a state change
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (reload_i || (cnt_q == LAST)) cnt_d = '0;
  end

  // counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign bit_end_o = (cnt_q == LAST);
endmodule

// File: rtl/fifo_uart_tx.sv
// Drains a byte FIFO and serialises each word as an 8N1 UART frame.
// Optional even parity bit: define FIFO_UART_PARITY_EN.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned DATA_W       = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  fifo_uart_tx_if.master         bus
);
  localparam int unsigned      IDX_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  uart_tx_state_t    state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              tx_q, tx_d;
  logic [15:0]       sent_q, sent_d;
  logic              bit_end;
  logic              reload;

  assign reload = (state_d != state_q);

  uart_baud_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk       (clk),
    .rst       (rst),
    .reload_i  (reload),
    .bit_end_o (bit_end)
  );

  // next state, payload capture, bit index, frame counter and line level
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    sent_d  = sent_q;
    tx_d    = 1'b1;

    case (state_q)
      ST_IDLE:  if (bus.enable && !bus.fifo_empty) state_d = ST_FETCH;
      ST_FETCH: state_d = ST_LOAD;
      ST_LOAD: begin
        shift_d = bus.fifo_data;
        idx_d   = '0;
        state_d = ST_START;
      end
      ST_START: if (bit_end) state_d = ST_DATA;
      ST_DATA: begin
        if (bit_end) begin
          if (idx_q == LAST_IDX) begin
`ifdef FIFO_UART_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
`ifdef FIFO_UART_PARITY_EN
      ST_PARITY: if (bit_end) state_d = ST_STOP;
`endif
      ST_STOP: begin
        if (bit_end) begin
          state_d = ST_IDLE;
          sent_d  = sent_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // tx is registered, so its level is decoded from the state being entered
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_q[idx_d];
`ifdef FIFO_UART_PARITY_EN
      ST_PARITY: tx_d = ^shift_q;
`endif
      default:   tx_d = 1'b1;
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
      sent_q  <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      sent_q  <= sent_d;
    end
  end

  assign bus.tx         = tx_q;
  assign bus.fifo_rd_en = (state_q == ST_FETCH);
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.frame_done = (state_q == ST_STOP) && bit_end;
  assign bus.bytes_sent = sent_q;
endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Downstream drain stage for the 512-deep byte FIFO. It pops bytes from the FIFO read port in the 16 MHz domain and serialises each one as an 8N1 UART frame (optionally 8E1) on `tx`. The block owns the FIFO's `rd_en`, and is the sole reader of that FIFO.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 139: clock cycles per UART bit. 139 gives about 115200 baud at 16 MHz. Legal range is ≥2.
- `DATA_W`, default 8: frame payload width. It equals the FIFO word width.

Ports:
- `clk`  in  1  the FIFO read-side clock (16 MHz PLL output); single clock domain.
- `rst`  in  1  reset, asynchronous, active-high.
- `enable`  in  1  when 1, the block may start new frames.
- `fifo_empty`  in  1  FIFO `empty` flag.
- `fifo_data`  in  DATA_W  FIFO `data_out`; valid on the cycle after `fifo_rd_en`.
- `fifo_rd_en`  out  1  one-cycle pop strobe to the FIFO.
- `tx`  out  1  serial line, idle high.
- `busy`  out  1  high from FETCH through the end of STOP.
- `frame_done`  out  1  one-cycle pulse on the last cycle of STOP.
- `bytes_sent`  out  16  count of completed frames.

## Operation
- Moore FSM with states IDLE → FETCH → LOAD → START → DATA → [PARITY] → STOP → IDLE.
- IDLE:
  - Moves to FETCH when `enable && !fifo_empty`.
  - `fifo_empty` is sampled only in IDLE.
  - `tx` = 1.
- FETCH:
  - `fifo_rd_en` = 1 for exactly this one cycle.
  - Moves unconditionally to LOAD.
- LOAD:
  - Captures `fifo_data` into the shift register at the end of this cycle.
  - Moves to START.
- START: `tx` = 0 for CLKS_PER_BIT cycles.
- DATA:
  - Sends DATA_W bits, LSB first, each for CLKS_PER_BIT cycles.
  - The bit index runs 0..DATA_W-1.
- STOP:
  - `tx` = 1 for CLKS_PER_BIT cycles.
  - `frame_done` pulses on the final cycle of STOP.
  - `bytes_sent` increments by 1 on that same edge.
- Baud counter:
  - Width is $clog2(CLKS_PER_BIT).
  - Counts 0..CLKS_PER_BIT-1 and reloads to 0 on every state change.
- `tx` is registered, so it changes only on clock edges and is glitch-free.
- `bytes_sent` wraps from 16'hFFFF to 0.
- Deasserting `enable` mid-frame has no effect on the current frame; it completes normally. Only new frame starts are suppressed.
- If `fifo_empty` rises during LOAD through STOP, it is ignored.
- Reset values: `tx`=1, `fifo_rd_en`=0, `busy`=0, `frame_done`=0, `bytes_sent`=0, state=IDLE, shift register=0.
- Reset mid-frame:
  - `tx` returns high asynchronously.
  - The popped byte is discarded and is not re-read.

## Timing
- Pop-to-start latency: `fifo_rd_en` high in cycle n, `tx` falls at the edge starting cycle n+2.
- Frame length without parity: (DATA_W+2)·CLKS_PER_BIT cycles.
- Back-to-back frames with a non-empty FIFO: the minimum idle gap between the end of STOP and the next start bit is 3 cycles (IDLE, FETCH, LOAD). `tx` stays high throughout that gap.
- Throughput: the block never pops while `busy`. At most one outstanding read at a time.

## Configuration
- Macro `FIFO_UART_PARITY_EN`.
  - Defined: the PARITY state is inserted after DATA. It sends the even-parity bit (XOR of the payload) for CLKS_PER_BIT cycles. Frame length is (DATA_W+3)·CLKS_PER_BIT.
  - Undefined: DATA goes directly to STOP, and no parity logic is compiled.

## Structure
- Package `fifo_uart_pkg` holds:
  - the state enum `uart_tx_state_t`;
  - `DEFAULT_CLKS_PER_BIT` = 139;
  - `IDLE_GAP_CYCLES` = 3.
- Sub-module `uart_baud_gen`: bit-period counter with a synchronous reload input, emitting `bit_end`. The FSM, shift register and `bytes_sent` counter live in the top module.

## Test plan
Bench uses CLKS_PER_BIT=4 unless stated.
- Reset: hold `rst`=1, then release → `tx`=1, `busy`=0, `bytes_sent`=0. No `fifo_rd_en` while `fifo_empty`=1.
- Single byte 8'hA5, `enable`=1:
  - exactly one `fifo_rd_en` pulse;
  - `tx` sequence 0,1,0,1,0,0,1,0,1,1, each held 4 cycles;
  - `frame_done` pulse;
  - `bytes_sent`=1;
  - start bit 2 cycles after the pop.
- FIFO preloaded with 512 bytes 1..512 mod 256:
  - 512 frames received in order;
  - each inter-frame gap is 3 cycles;
  - `bytes_sent`=512;
  - the FIFO drains to empty and no further `fifo_rd_en` is issued.
- Drop `enable` during DATA of byte 8'h3C → that frame completes; no further FETCH until `enable`=1 again.
- Assert `rst` mid-DATA → `tx`=1 immediately; resumes with the next FIFO byte after release; `bytes_sent` reset to 0.
- With `FIFO_UART_PARITY_EN` and byte 8'h07 → parity bit 1 after DATA; frame length 44 cycles.
